// File: rtl/addsub_seq_pkg.sv
// Shared definitions for the slice-serial add/subtract sequencer:
// FSM state encoding, slice width and the slice-index width helper.
package addsub_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_W = 2;

    // Width of the slice index counter: enough for WIDTH/2 slices, never below 1 bit.
    function automatic int idx_width(input int width);
        int n;
        n = $clog2(width / SLICE_W);
        if (n < 1) n = 1;
        return n;
    endfunction

endpackage

// File: rtl/addsub2_slice.sv
// Combinational 2-bit full-adder slice. The controller pre-inverts b for
// subtraction; c1 exposes the carry into bit 1 for signed-overflow detection.
module addsub2_slice
    import addsub_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout,
    output logic               c1
);

    assign s[0] = a[0] ^ b[0] ^ cin;
    assign c1   = (a[0] & b[0]) | (a[0] & cin) | (b[0] & cin);
    assign s[1] = a[1] ^ b[1] ^ c1;
    assign cout = (a[1] & b[1]) | (a[1] & c1) | (b[1] & c1);

endmodule

// File: rtl/addsub_seq_ctrl.sv
// WIDTH-bit add/subtract sequencer: streams 2-bit operand slices LSB first
// through one addsub2_slice, one slice per cycle, with a registered carry.
// Optional feature macro: ADDSUB_SEQ_OVF_EN enables the registered signed
// overflow flag; when undefined, ovf is tied low.
module addsub_seq_ctrl
    import addsub_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int NSL = WIDTH / SLICE_W;
    localparam int IW  = idx_width(WIDTH);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_sub;
    logic               r_c;
    logic [IW-1:0]      r_idx;
    logic [WIDTH-1:0]   r_result;
    logic               r_cout;

    logic               w_accept;
    logic               w_last;
    logic [IW:0]        w_base;
    logic [SLICE_W-1:0] w_sa;
    logic [SLICE_W-1:0] w_sb;
    logic [SLICE_W-1:0] w_s;
    logic               w_co;

    // start is only honoured when no operation is in flight
    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_idx == IW'(NSL - 1));
    assign w_base   = {r_idx, 1'b0};
    assign w_sa     = r_a[w_base +: SLICE_W];
    assign w_sb     = r_b[w_base +: SLICE_W] ^ {SLICE_W{r_sub}};

`ifdef ADDSUB_SEQ_OVF_EN
    logic w_c1;
`else
    logic w_c1_unused;
`endif

    addsub2_slice u_slice (
        .a    (w_sa),
        .b    (w_sb),
        .cin  (r_c),
        .s    (w_s),
        .cout (w_co),
`ifdef ADDSUB_SEQ_OVF_EN
        .c1   (w_c1)
`else
        .c1   (w_c1_unused)
`endif
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic: DONE lasts one cycle and can chain straight into RUN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = start ? RUN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        busy = (r_state == RUN);
        done = (r_state == DONE);
    end

    // Operand capture; only meaningful after an accept, so no reset needed
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_sub <= sub;
        end
    end

    // Slice sequencing: carry seeded with sub (the +1 of two's complement),
    // one result slice written per RUN cycle, cout captured on the last slice
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c      <= 1'b0;
            r_idx    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
        end else if (w_accept) begin
            r_c   <= sub;
            r_idx <= '0;
        end else if (r_state == RUN) begin
            r_result[w_base +: SLICE_W] <= w_s;
            r_c                         <= w_co;
            r_idx                       <= r_idx + IW'(1);
            if (w_last) r_cout <= w_co;
        end
    end

`ifdef ADDSUB_SEQ_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of the MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           r_ovf <= 1'b0;
        else if ((r_state == RUN) && w_last)  r_ovf <= w_c1 ^ w_co;
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign result = r_result;
    assign cout   = r_cout;

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed self-checking bench for addsub_seq_ctrl (WIDTH=8).
module tb_addsub_seq_ctrl;

    localparam int WIDTH = 8;
`ifdef ADDSUB_SEQ_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    int n_checks = 0;
    int n_errors = 0;

    addsub_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ovf(input logic v);
        return OVF_ON ? v : 1'b0;
    endfunction

    // One full operation: accept, check latency, outputs and done falling.
    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic isub, input logic [7:0] eres, input logic ecout,
                          input logic eovf);
        int k;
        @(negedge clk);
        a = ia; b = ib; sub = isub; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk($sformatf("%s_busy", tag), {31'd0, busy}, 32'd1);
        for (k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        chk($sformatf("%s_latency", tag), k, 4);
        chk($sformatf("%s_res", tag), {24'd0, result}, {24'd0, eres});
        chk($sformatf("%s_cout", tag), {31'd0, cout}, {31'd0, ecout});
        chk($sformatf("%s_ovf", tag), {31'd0, ovf}, {31'd0, exp_ovf(eovf)});
        chk($sformatf("%s_busy_in_done", tag), {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk($sformatf("%s_done_fall", tag), {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int ndone;
        int npulse;
        int bad;
        int cyc;
        int t_prev;
        int gap_err;
        logic [7:0] seen;
        logic       alt;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_done",   {31'd0, done}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_cout",   {31'd0, cout}, 32'd0);
        chk("rst_ovf",    {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_op("add5a33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
        run_op("sub1020", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op("addff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("sub8001", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // start re-pulsed mid-operation must be ignored
        @(negedge clk);
        a = 8'h5A; b = 8'h33; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'h11; b = 8'h22; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; seen = '0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                seen = result;
            end
        end
        chk("midrun_done_count", ndone, 1);
        chk("midrun_result", {24'd0, seen}, 32'h8D);

        // start held high: alternating 0x01+0x01 and 0x03-0x01
        @(negedge clk);
        a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
        npulse = 0; bad = 0; t_prev = -1; gap_err = 0; alt = 1'b0;
        @(posedge clk);
        for (cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                npulse++;
                chk($sformatf("held_res%0d", npulse), {24'd0, result}, 32'h02);
                if (busy) bad++;
                if (t_prev >= 0 && (cyc - t_prev) != 5) gap_err++;
                t_prev = cyc;
                alt = ~alt;
                if (alt) begin a = 8'h03; b = 8'h01; sub = 1'b1; end
                else     begin a = 8'h01; b = 8'h01; sub = 1'b0; end
                if (npulse == 3) begin
                    start = 1'b0;
                    break;
                end
            end else if (!busy) begin
                bad++;
            end
        end
        chk("held_pulses", npulse, 3);
        chk("held_gap", gap_err, 0);
        chk("held_busy_pattern", bad, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("held_idle", {30'd0, busy, done}, 32'd0);

        // reset asserted in the third RUN cycle aborts the operation
        run_op("sub8001b", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        @(negedge clk);
        a = 8'hAA; b = 8'h00; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",   {31'd0, busy}, 32'd0);
        chk("abort_done",   {31'd0, done}, 32'd0);
        chk("abort_result", {24'd0, result}, 32'd0);
        chk("abort_cout",   {31'd0, cout}, 32'd0);
        chk("abort_ovf",    {31'd0, ovf}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        run_op("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        run_op("add7f01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
